// File: rtl/seg_pkg.sv
// Shared glyph constants for the multiplexed seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, and a 1 lights the segment.
package seg_pkg;

  typedef logic [6:0] glyph_t;

  // Hex glyphs 0..F. Element 15 is listed first.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam glyph_t GLYPH_DASH  = 7'h40;
  localparam glyph_t GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus bundle for seg_scan_driver: host-side controls and the scanned outputs.
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    hex_mode;
  logic                    blank_lz;
  logic                    enable;
  glyph_t                  seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    scan_tick;

  modport master (
    output value, dp_in, load, hex_mode, blank_lz, enable,
    input  seg, dp, an, scan_tick
  );

  modport slave (
    input  value, dp_in, load, hex_mode, blank_lz, enable,
    output seg, dp, an, scan_tick
  );
endinterface

// File: rtl/seg_glyph.sv
// Combinational code-to-glyph translation. The output is active-high.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  // In decimal mode, codes above 9 show a dash. Blanking overrides everything.
  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) begin
      if ((code > 4'd9) && !hex_mode) seg = GLYPH_DASH;
      else                            seg = GLYPH_HEX[code];
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a shadow register, leading-zero
// blanking, and polarity applied only at the output registers.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_MASK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] codes_q, codes_d;
  logic [NUM_DIGITS-1:0]      dps_q, dps_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic                       tick_q, tick_d;

  logic [NUM_DIGITS-1:0]      blank_vec;
  logic                       higher_zero;
  logic [NUM_DIGITS-1:0]      onehot;
  logic [6:0]                 glyph_seg;

  // A digit is blanked when it and every higher digit hold code 0.
  // The scan walks from the top digit down, and digit 0 is always shown.
  always_comb begin
    blank_vec   = '0;
    higher_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      higher_zero = higher_zero && (codes_q[NUM_DIGITS-1-j] == 4'd0);
      blank_vec[NUM_DIGITS-1-j] = blank_lz && higher_zero && (j != NUM_DIGITS-1);
    end
  end

  seg_glyph u_glyph (
    .code     (codes_q[idx_q]),
    .hex_mode (hex_mode),
    .blank    (blank_vec[idx_q]),
    .seg      (glyph_seg)
  );

  // Next state for the refresh counter, the digit index, the tick and the shadow register.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    codes_d = codes_q;
    dps_d   = dps_q;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (load) begin
      codes_d = value;
      dps_d   = dp_in;
    end
  end

  // Output values computed from the current index and shadow data, with polarity applied last.
  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
    seg_d         = SEG_MASK;
    dp_d          = DP_MASK;
    an_d          = AN_MASK;
    if (enable) begin
      seg_d = glyph_seg ^ SEG_MASK;
      dp_d  = dps_q[idx_q] ^ DP_MASK;
      an_d  = onehot ^ AN_MASK;
    end
  end

  // State and output registers. Synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      codes_q <= '0;
      dps_q   <= '0;
      seg_q   <= SEG_MASK;
      dp_q    <= DP_MASK;
      an_q    <= AN_MASK;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      codes_q <= codes_d;
      dps_q   <= dps_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 4-cycle refresh).
// A reference model pushes the expected post-edge outputs on every rising edge.
// A monitor pops one entry on each falling edge and compares it with the DUT outputs.
module tb_seg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (DIV),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (bus.value),
    .dp_in     (bus.dp_in),
    .load      (bus.load),
    .hex_mode  (bus.hex_mode),
    .blank_lz  (bus.blank_lz),
    .enable    (bus.enable),
    .seg       (bus.seg),
    .dp        (bus.dp),
    .an        (bus.an),
    .scan_tick (bus.scan_tick)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state. The scan position follows from the number of enabled
  // cycles since the last reset.
  int         m_active = 0;
  logic [3:0] m_codes [N];
  logic [N-1:0] m_dp = '0;

  function automatic logic [6:0] ref_glyph(input int code, input bit hex);
    case (code)
      0:  return 7'b0111111;
      1:  return 7'b0000110;
      2:  return 7'b1011011;
      3:  return 7'b1001111;
      4:  return 7'b1100110;
      5:  return 7'b1101101;
      6:  return 7'b1111101;
      7:  return 7'b0000111;
      8:  return 7'b1111111;
      9:  return 7'b1101111;
      10: return hex ? 7'b1110111 : 7'b1000000;
      11: return hex ? 7'b1111100 : 7'b1000000;
      12: return hex ? 7'b0111001 : 7'b1000000;
      13: return hex ? 7'b1011110 : 7'b1000000;
      14: return hex ? 7'b1111001 : 7'b1000000;
      default: return hex ? 7'b1110001 : 7'b1000000;
    endcase
  endfunction

  // Model: compute the outputs that should appear after this edge, then update the model state.
  always @(posedge clk) begin : model
    exp_t e;
    int   d;
    bit   allz;
    e = '{seg: 7'h00, dp: 1'b0, an: 4'hF, tick: 1'b0};
    if (!rst_n) begin
      m_active = 0;
      m_dp     = '0;
      for (int k = 0; k < N; k++) m_codes[k] = 4'h0;
    end else begin
      if (bus.enable) begin
        d    = (m_active / DIV) % N;
        allz = 1'b1;
        for (int k = d; k < N; k++) if (m_codes[k] != 4'h0) allz = 1'b0;
        e.seg  = (bus.blank_lz && d != 0 && allz) ? 7'h00 : ref_glyph(int'(m_codes[d]), bus.hex_mode);
        e.dp   = m_dp[d];
        e.an   = ~(4'b0001 << d);
        e.tick = ((m_active % DIV) == DIV - 1);
        m_active++;
      end
      if (bus.load) begin
        for (int k = 0; k < N; k++) m_codes[k] = bus.value[4*k +: 4];
        m_dp = bus.dp_in;
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare one expected entry per cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.seg !== e.seg || bus.dp !== e.dp || bus.an !== e.an || bus.scan_tick !== e.tick) begin
        n_fail++;
        $display("FAIL outputs @%0t: got seg=%b dp=%b an=%b tick=%b, expected seg=%b dp=%b an=%b tick=%b",
                 $time, bus.seg, bus.dp, bus.an, bus.scan_tick, e.seg, e.dp, e.an, e.tick);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
    bus.value = v;
    bus.dp_in = dpv;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Step until the model reaches the requested digit (-1 = any) and count. A bounded wait that times out counts as a failed check.
  task automatic wait_pos(input int digit, input int cnt, input string name);
    int guard;
    guard = 0;
    while (!(((digit < 0) || ((m_active / DIV) % N == digit)) && (m_active % DIV == cnt)) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scan position not reached, got cnt=%0d, expected cnt=%0d", name, m_active % DIV, cnt);
    end
  endtask

  initial begin : stim
    logic [15:0] mask;
    rst_n        = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.enable   = 1'b1;
    cycles(3);

    // Release reset, load 1234, and scan through all four digits several times.
    rst_n = 1'b1;
    do_load(16'h1234, 4'b0000);
    cycles(20);

    // Codes A and F in decimal mode, then in hex mode.
    do_load(16'h00AF, 4'b0010);
    cycles(8);
    bus.hex_mode = 1'b1;
    cycles(8);

    // Leading-zero blanking with value 0005, then 0000, then blanking off.
    bus.blank_lz = 1'b1;
    do_load(16'h0005, 4'b1000);
    cycles(16);
    do_load(16'h0000, 4'b0100);
    cycles(16);
    bus.blank_lz = 1'b0;

    // Disable the display in the middle of digit 2, then resume.
    do_load(16'h1234, 4'b0101);
    wait_pos(2, 1, "pause_pos");
    bus.enable = 1'b0;
    cycles(10);
    bus.enable = 1'b1;
    cycles(12);

    // Load on the terminal-count cycle.
    wait_pos(-1, DIV - 1, "tc_pos");
    do_load(16'h9876, 4'b1111);
    cycles(8);

    // Reset in the middle of a scan.
    wait_pos(-1, 2, "rst_pos");
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.load   = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      bus.value = 16'($urandom) & mask;
      bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.hex_mode = ~bus.hex_mode;
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      @(negedge clk);
    end
    bus.load = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
